iir_stream_ctrl: RTL and testbench
==================================

// Module: iir_stream_ctrl
// PURPOSE
//  Sequences the 11-bit iir cascade (input reg + section1 + section2) for the spike detector.
//  - Flushes filter state with zeros, then masks the warm-up transient; tags valid outputs.
//  - Feeds the filter every clock, applying zero-order hold on sensor gaps; counts gaps.
//  - Sits between the sensor sample stream and the spike threshold logic.
// PARAMETERS
//  W          11  sample width, two's complement, shared by filter x and z
//  LATENCY    3   clocks from filter x to the matching z (decided pipeline depth)
//  FLUSH_LEN  16  zero samples driven into the filter in FLUSH (>=1)
//  SETTLE_LEN 32  accepted samples whose outputs are suppressed after FLUSH (>=1)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  start      in   1   pulse: begin a run (acted on in IDLE only)
//  stop       in   1   pulse: end a run (acted on outside IDLE)
//  s_valid    in   1   sensor sample valid
//  s_data     in   W   sensor sample, signed
//  s_ready    out  1   ctrl accepts s_data this cycle
//  iir_x      out  W   sample driven to filter x
//  iir_z      in   W   filter output z
//  m_valid    out  1   m_data is a genuine filtered sample
//  m_data     out  W   registered copy of iir_z
//  state      out  2   0 IDLE, 1 FLUSH, 2 SETTLE, 3 RUN (DRAIN reports 3)
//  gap_cnt    out  8   saturating count of s_valid-low cycles in SETTLE/RUN; cleared on start
// BEHAVIOUR
//  Reset: state IDLE, iir_x 0, m_valid 0, m_data 0, s_ready 0, gap_cnt 0, all counters/tags 0.
//  IDLE: iir_x=0. start -> FLUSH (counter=0, gap_cnt=0). start&stop same cycle -> stay IDLE.
//  FLUSH: iir_x=0 for exactly FLUSH_LEN cycles, then SETTLE. stop -> IDLE immediately.
//  SETTLE: s_ready=1. Accept when s_valid: iir_x<=s_data, count accepted; counter reaching
//   SETTLE_LEN -> RUN. Outputs of SETTLE samples never flagged valid.
//  RUN: s_ready=1; accepted sample tagged valid (tag enters LATENCY-deep shift reg).
//  Gap (SETTLE/RUN, s_valid=0): iir_x holds last value, tag=0, gap_cnt+1 (sticks at 255).
//  iir_x is registered: accepted s_data appears on iir_x the next cycle.
//  m_valid/m_data: registered; sample accepted at cycle t -> m_valid=1 at t+1+LATENCY.
//  stop in SETTLE/RUN -> DRAIN: s_ready=0, iir_x holds, no new tags; in-flight tags still
//   emerge; after LATENCY+1 cycles -> IDLE. start ignored in FLUSH/SETTLE/RUN/DRAIN.
//  Async reset mid-run: all outputs to reset values immediately; next start re-flushes.
//  No arithmetic on data; widths pass through unchanged, no saturation.
// TESTING
//  T1 reset low mid-RUN with m_valid=1 -> m_valid 0, state 0, iir_x 0 asynchronously.
//  T2 start, FLUSH_LEN=16 -> state=1 for 16 cycles, iir_x=0 throughout, then state=2.
//  T3 SETTLE_LEN=32 continuous ramp 1..40 -> state=3 after sample 32; m_valid first high
//     for sample 33, exactly LATENCY+1 cycles after its accept; 8 valid outputs total.
//  T4 RUN, s_valid low 3 cycles after s_data=-100 -> iir_x stays -100, gap_cnt=3,
//     3-cycle hole in m_valid aligned to the gap.
//  T5 stop with 2 samples in flight -> both emerge with m_valid, s_ready 0, IDLE after 4.
//  T6 300 gap cycles -> gap_cnt=255; start&stop same cycle in IDLE -> stays IDLE.

Source files
------------

// File: rtl/iir_stream_ctrl.sv
// Stream sequencer for the spike-detector IIR cascade: flushes filter state, masks the
// warm-up transient, holds the last sample across sensor gaps and tags genuine outputs.
module iir_stream_ctrl #(
  parameter int W          = 11,
  parameter int LATENCY    = 3,
  parameter int FLUSH_LEN  = 16,
  parameter int SETTLE_LEN = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         s_valid_i,
  input  logic [W-1:0] s_data_i,
  output logic         s_ready_o,
  output logic [W-1:0] iir_x_o,
  input  logic [W-1:0] iir_z_i,
  output logic         m_valid_o,
  output logic [W-1:0] m_data_o,
  output logic [1:0]   state_o,
  output logic [7:0]   gap_cnt_o
);

  localparam int CMAX = (FLUSH_LEN > SETTLE_LEN) ? FLUSH_LEN : SETTLE_LEN;
  localparam int CW   = $clog2(CMAX + LATENCY + 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [W-1:0]         x_q, x_d;
  logic [7:0]           gap_q, gap_d;
  logic [LATENCY-1:0]   tag_q;
  logic                 tag_in;
  logic                 m_valid_q;
  logic [W-1:0]         m_data_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    gap_d     = gap_q;
    tag_in    = 1'b0;
    s_ready_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        x_d = '0;
        if (start_i && !stop_i) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
          gap_d   = '0;
        end
      end
      S_FLUSH: begin
        x_d = '0;
        if (stop_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(FLUSH_LEN - 1)) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETTLE, S_RUN: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          x_d    = s_data_i;
          tag_in = (state_q == S_RUN);
          if (state_q == S_SETTLE) begin
            if (cnt_q == CW'(SETTLE_LEN - 1)) begin
              state_d = S_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end else if (gap_q != 8'hFF) begin
          gap_d = gap_q + 8'd1;
        end
        // A sample offered alongside stop is still taken; stop wins over SETTLE->RUN.
        if (stop_i) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(LATENCY)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          x_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        x_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      gap_q   <= gap_d;
    end
  end

  // Tag travels alongside the sample so m_valid lines up with its filtered value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      m_valid_q <= tag_q[LATENCY-1];
      m_data_q  <= iir_z_i;
    end
  end

  assign iir_x_o   = x_q;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign gap_cnt_o = gap_q;
  assign state_o   = (state_q == S_DRAIN) ? 2'd3 : state_q[1:0];

endmodule

// File: tb/tb_iir_stream_ctrl.sv
// Directed bench for iir_stream_ctrl; the two filter sections are modelled as a plain
// two-register delay behind the controller's own iir_x register.
module tb_iir_stream_ctrl;

  localparam logic [10:0] NEG100 = 11'h79C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, s_valid = 1'b0;
  logic [10:0] s_data = '0;
  logic        s_ready, m_valid;
  logic [10:0] iir_x, iir_z, m_data;
  logic [1:0]  state;
  logic [7:0]  gap_cnt;

  logic [10:0] z1 = '0, z2 = '0;
  int total = 0, bad = 0;
  int cyc = 0, vcnt = 0;
  bit          exp_v [0:1023];
  logic [10:0] exp_d [0:1023];

  iir_stream_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .iir_x_o(iir_x), .iir_z_i(iir_z), .m_valid_o(m_valid), .m_data_o(m_data),
    .state_o(state), .gap_cnt_o(gap_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    z1 <= iir_x;
    z2 <= z1;
  end
  assign iir_z = z2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock: drive inputs, advance, then check m_valid/m_data against the expected tags.
  task automatic clk1(input logic v, input logic [10:0] d, input logic tg,
                      input logic st, input logic sp);
    s_valid = v; s_data = d; start = st; stop = sp;
    if (tg) begin
      exp_v[(cyc + 4) & 1023] = 1'b1;
      exp_d[(cyc + 4) & 1023] = d;
    end
    if (v) $display("cycle %0d: offer sample %0d tagged=%0d", cyc, $signed(d), tg);
    @(posedge clk); #1;
    cyc++;
    s_valid = 1'b0; start = 1'b0; stop = 1'b0;
    chk("m_valid", 32'(m_valid), 32'(exp_v[cyc & 1023]));
    if (exp_v[cyc & 1023]) chk("m_data", 32'(m_data), 32'(exp_d[cyc & 1023]));
    if (m_valid) vcnt++;
    exp_v[cyc & 1023] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk1(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin exp_v[i] = 1'b0; exp_d[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_iir_x", 32'(iir_x), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_gap", 32'(gap_cnt), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // T2: flush
    clk1(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("flush_state", 32'(state), 1);
      chk("flush_x", 32'(iir_x), 0);
      idle(1);
    end
    chk("settle_entry", 32'(state), 2);
    chk("settle_ready", 32'(s_ready), 1);

    // T3: ramp 1..40
    vcnt = 0;
    for (int i = 1; i <= 32; i++) begin
      clk1(1'b1, 11'(i), 1'b0, 1'b0, 1'b0);
      if (i == 31) chk("still_settle", 32'(state), 2);
    end
    chk("run_entry", 32'(state), 3);
    for (int i = 33; i <= 40; i++) clk1(1'b1, 11'(i), 1'b1, 1'b0, 1'b0);
    chk("ramp_x", 32'(iir_x), 40);

    // T4: -100 then 3-cycle gap
    clk1(1'b1, NEG100, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("gap_hold_x", 32'(iir_x), 32'(NEG100));
    end
    chk("gap_cnt3", 32'(gap_cnt), 3);

    // T5: two samples then stop
    clk1(1'b1, 11'd7, 1'b1, 1'b0, 1'b0);
    clk1(1'b1, 11'd8, 1'b1, 1'b0, 1'b0);
    clk1(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("drain_state", 32'(state), 3);
      chk("drain_ready", 32'(s_ready), 0);
      chk("drain_x", 32'(iir_x), 8);
      clk1(1'b1, 11'd99, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_last", 32'(state), 3);
    idle(1);
    chk("drain_idle", 32'(state), 0);
    chk("idle_x", 32'(iir_x), 0);
    chk("valid_total", 32'(vcnt), 11);

    // stop during FLUSH
    clk1(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(3);
    chk("flush2_state", 32'(state), 1);
    clk1(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("flush_stop", 32'(state), 0);

    // T6: gap saturation, then start&stop in IDLE
    clk1(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("gap_cleared", 32'(gap_cnt), 0);
    idle(16);
    chk("t6_settle", 32'(state), 2);
    idle(255);
    chk("gap_255", 32'(gap_cnt), 255);
    idle(45);
    chk("gap_sat", 32'(gap_cnt), 255);
    chk("t6_still_settle", 32'(state), 2);
    clk1(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("t6_idle", 32'(state), 0);
    clk1(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("start_stop_idle", 32'(state), 0);
    idle(1);
    chk("start_stop_idle2", 32'(state), 0);

    // T1: async reset mid-RUN
    clk1(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(16);
    for (int i = 1; i <= 32; i++) clk1(1'b1, 11'(i + 100), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) clk1(1'b1, 11'(200 + i), 1'b1, 1'b0, 1'b0);
    chk("t1_pre_valid", 32'(m_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_m_valid", 32'(m_valid), 0);
    chk("t1_state", 32'(state), 0);
    chk("t1_iir_x", 32'(iir_x), 0);
    chk("t1_s_ready", 32'(s_ready), 0);
    chk("t1_m_data", 32'(m_data), 0);
    for (int i = 0; i < 1024; i++) exp_v[i] = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc++;
    clk1(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("t1_reflush", 32'(state), 1);
    chk("t1_reflush_x", 32'(iir_x), 0);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
